// File: rtl/reg_writeback_stage.sv
// Register-file write-back stage: result/load select, zero-register suppression, load-wait stall.
// Optional feature: define WB_STALL_CNT_EN to count cycles spent waiting for load data.
module reg_writeback_stage #(
    parameter int unsigned           DATA_W            = 16,
    parameter int unsigned           IDX_W             = 5,
    parameter int unsigned           CTRL_W            = 4,
    parameter logic [CTRL_W-1:0]     LOAD_OP           = CTRL_W'(4'b1100),
    parameter logic [CTRL_W-1:0]     LOADB_OP          = CTRL_W'(4'b1101),
    parameter bit                    ZERO_IDX_SUPPRESS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_ma,
    output logic              in_ready_wb,
    input  logic [IDX_W-1:0]  dest_reg_index_ma,
    input  logic              dest_reg_write_en_ma,
    input  logic [DATA_W-1:0] result_ma,
    input  logic [DATA_W-1:0] data_ma,
    input  logic              data_valid_ma,
    input  logic [CTRL_W-1:0] control_ma,
    output logic [IDX_W-1:0]  write_index_rf,
    output logic [DATA_W-1:0] write_data_rf,
    output logic              write_en_rf,
    output logic              fwd_valid,
    output logic [IDX_W-1:0]  fwd_index,
    output logic [DATA_W-1:0] fwd_data,
    output logic [15:0]       stall_cycles
);

    typedef enum logic [0:0] {StReady, StWaitLoad} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    cap_idx_q, cap_idx_d;
    logic                cap_we_q, cap_we_d;
    logic [CTRL_W-1:0]   cap_ctrl_q, cap_ctrl_d;
    logic [IDX_W-1:0]    widx_q, widx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wen_q, wen_d;
    logic                is_load;

    function automatic logic [DATA_W-1:0] load_data(input logic [DATA_W-1:0] d,
                                                    input logic [CTRL_W-1:0] ctrl);
        if (ctrl == LOADB_OP) begin
            return {{(DATA_W-8){d[7]}}, d[7:0]};
        end
        return d;
    endfunction

    function automatic logic zero_hit(input logic [IDX_W-1:0] idx);
        return ZERO_IDX_SUPPRESS && (idx == '0);
    endfunction

    assign is_load = (control_ma == LOAD_OP) || (control_ma == LOADB_OP);

    always_comb begin
        state_d    = state_q;
        cap_idx_d  = cap_idx_q;
        cap_we_d   = cap_we_q;
        cap_ctrl_d = cap_ctrl_q;
        widx_d     = widx_q;
        wdata_d    = wdata_q;
        wen_d      = 1'b0;
        unique case (state_q)
            StReady: begin
                if (in_valid_ma) begin
                    if (is_load && !data_valid_ma) begin
                        cap_idx_d  = dest_reg_index_ma;
                        cap_we_d   = dest_reg_write_en_ma;
                        cap_ctrl_d = control_ma;
                        state_d    = StWaitLoad;
                    end else begin
                        widx_d  = dest_reg_index_ma;
                        wdata_d = is_load ? load_data(data_ma, control_ma) : result_ma;
                        wen_d   = dest_reg_write_en_ma && !zero_hit(dest_reg_index_ma);
                    end
                end
            end
            StWaitLoad: begin
                // Upstream holds its instruction here; only the data strobe matters.
                if (data_valid_ma) begin
                    widx_d  = cap_idx_q;
                    wdata_d = load_data(data_ma, cap_ctrl_q);
                    wen_d   = cap_we_q && !zero_hit(cap_idx_q);
                    state_d = StReady;
                end
            end
            default: state_d = StReady;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StReady;
            cap_idx_q  <= '0;
            cap_we_q   <= 1'b0;
            cap_ctrl_q <= '0;
            widx_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_idx_q  <= cap_idx_d;
            cap_we_q   <= cap_we_d;
            cap_ctrl_q <= cap_ctrl_d;
            widx_q     <= widx_d;
            wdata_q    <= wdata_d;
            wen_q      <= wen_d;
        end
    end

    assign in_ready_wb    = (state_q == StReady);
    assign write_index_rf = widx_q;
    assign write_data_rf  = wdata_q;
    assign write_en_rf    = wen_q;
    assign fwd_valid      = wen_q;
    assign fwd_index      = widx_q;
    assign fwd_data       = wdata_q;

`ifdef WB_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == StWaitLoad && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0;
`endif

endmodule

// File: tb/tb_reg_writeback_stage.sv
// Self-checking bench for reg_writeback_stage: directed scenarios then random traffic
// compared against a transaction-level model (pending-load queue + expected write record).
module tb_reg_writeback_stage;

    localparam logic [3:0] LoadOp  = 4'b1100;
    localparam logic [3:0] LoadbOp = 4'b1101;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_ma;
    logic        in_ready_wb;
    logic [4:0]  dest_reg_index_ma;
    logic        dest_reg_write_en_ma;
    logic [15:0] result_ma;
    logic [15:0] data_ma;
    logic        data_valid_ma;
    logic [3:0]  control_ma;
    logic [4:0]  write_index_rf;
    logic [15:0] write_data_rf;
    logic        write_en_rf;
    logic        fwd_valid;
    logic [4:0]  fwd_index;
    logic [15:0] fwd_data;
    logic [15:0] stall_cycles;

    reg_writeback_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid_ma          (in_valid_ma),
        .in_ready_wb          (in_ready_wb),
        .dest_reg_index_ma    (dest_reg_index_ma),
        .dest_reg_write_en_ma (dest_reg_write_en_ma),
        .result_ma            (result_ma),
        .data_ma              (data_ma),
        .data_valid_ma        (data_valid_ma),
        .control_ma           (control_ma),
        .write_index_rf       (write_index_rf),
        .write_data_rf        (write_data_rf),
        .write_en_rf          (write_en_rf),
        .fwd_valid            (fwd_valid),
        .fwd_index            (fwd_index),
        .fwd_data             (fwd_data),
        .stall_cycles         (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a load still missing its data sits in pend_q.
    typedef struct {
        logic [4:0] idx;
        logic       we;
        logic       is_byte;
    } pend_t;

    pend_t       pend_q[$];
    logic [4:0]  m_idx   = '0;
    logic [15:0] m_data  = '0;
    logic        m_wen   = 1'b0;
    int          m_stall = 0;

    function automatic logic [15:0] sel_data(input logic [15:0] d, input logic is_byte);
        int v;
        if (!is_byte) return d;
        v = int'(d[7:0]);
        if (v >= 128) v = v - 256;
        return 16'(v);
    endfunction

    task automatic drive(input logic v, input logic [4:0] idx, input logic we,
                         input logic [15:0] res, input logic [15:0] dat, input logic dv,
                         input logic [3:0] ctrl);
        in_valid_ma          = v;
        dest_reg_index_ma    = idx;
        dest_reg_write_en_ma = we;
        result_ma            = res;
        data_ma              = dat;
        data_valid_ma        = dv;
        control_ma           = ctrl;
    endtask

    task automatic step();
        pend_t p;
        logic  ld;
        check_eq("in_ready", {31'd0, in_ready_wb}, {31'd0, pend_q.size() == 0});
        m_wen = 1'b0;
        if (rst) begin
            pend_q.delete();
            m_idx   = '0;
            m_data  = '0;
            m_stall = 0;
        end else if (pend_q.size() != 0) begin
            if (m_stall < 65535) m_stall++;
            if (data_valid_ma) begin
                p      = pend_q.pop_front();
                m_idx  = p.idx;
                m_data = sel_data(data_ma, p.is_byte);
                m_wen  = p.we && (p.idx != 0);
            end
        end else if (in_valid_ma) begin
            ld = (control_ma == LoadOp) || (control_ma == LoadbOp);
            if (ld && !data_valid_ma) begin
                p.idx     = dest_reg_index_ma;
                p.we      = dest_reg_write_en_ma;
                p.is_byte = (control_ma == LoadbOp);
                pend_q.push_back(p);
            end else begin
                m_idx  = dest_reg_index_ma;
                m_data = ld ? sel_data(data_ma, control_ma == LoadbOp) : result_ma;
                m_wen  = dest_reg_write_en_ma && (dest_reg_index_ma != 0);
            end
        end
        @(posedge clk);
        #1;
        check_eq("write_en", {31'd0, write_en_rf}, {31'd0, m_wen});
        check_eq("write_index", {27'd0, write_index_rf}, {27'd0, m_idx});
        check_eq("write_data", {16'd0, write_data_rf}, {16'd0, m_data});
        check_eq("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_wen});
        check_eq("fwd_index", {27'd0, fwd_index}, {27'd0, m_idx});
        check_eq("fwd_data", {16'd0, fwd_data}, {16'd0, m_data});
`ifdef WB_STALL_CNT_EN
        check_eq("stall_cycles", {16'd0, stall_cycles}, 32'(m_stall));
`else
        check_eq("stall_cycles", {16'd0, stall_cycles}, 32'd0);
`endif
    endtask

    initial begin
        logic [3:0] c;
        rst = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        // ALU op, then idle
        drive(1'b1, 5'd5, 1'b1, 16'h1234, 16'h0, 1'b0, 4'b0000);
        step();
        check_eq("alu_data", {16'd0, write_data_rf}, 32'h1234);
        drive(1'b0, 5'd0, 1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
        step();

        // Ready full-word load
        drive(1'b1, 5'd3, 1'b1, 16'h0, 16'hBEEF, 1'b1, LoadOp);
        step();
        check_eq("load_data", {16'd0, write_data_rf}, 32'hBEEF);
        check_eq("load_ready", {31'd0, in_ready_wb}, 32'd1);

        // Late byte load: accept with no data, three more waits, then data
        drive(1'b1, 5'd7, 1'b1, 16'h0, 16'h0, 1'b0, LoadbOp);
        step();
        for (int i = 0; i < 3; i++) step();
        drive(1'b1, 5'd7, 1'b1, 16'h0, 16'h0080, 1'b1, LoadbOp);
        step();
        check_eq("loadb_data", {16'd0, write_data_rf}, 32'hFF80);
        check_eq("loadb_wen", {31'd0, write_en_rf}, 32'd1);
`ifdef WB_STALL_CNT_EN
        check_eq("stall_after_loadb", {16'd0, stall_cycles}, 32'd4);
`else
        check_eq("stall_after_loadb", {16'd0, stall_cycles}, 32'd0);
`endif

        // Zero register
        drive(1'b1, 5'd0, 1'b1, 16'hFFFF, 16'h0, 1'b0, 4'b0000);
        step();
        check_eq("zero_wen", {31'd0, write_en_rf}, 32'd0);
        check_eq("zero_data", {16'd0, write_data_rf}, 32'hFFFF);

        // Reset while waiting for a load to r2
        drive(1'b1, 5'd2, 1'b1, 16'h0, 16'h0, 1'b0, LoadOp);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 5'd2, 1'b1, 16'h0, 16'h5A5A, 1'b1, LoadOp);
        step();
        check_eq("rst_mid_load_wen", {31'd0, write_en_rf}, 32'd0);
        check_eq("rst_mid_load_data", {16'd0, write_data_rf}, 32'd0);

        // Back-to-back ALU ops
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 1'b1, 16'(9 + i), 16'h0, 1'b0, 4'b0000);
            step();
            check_eq("b2b_data", {16'd0, write_data_rf}, 32'(9 + i));
        end

        // Random traffic, loads biased up, occasional reset
        for (int n = 0; n < 600; n++) begin
            c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) c = ($urandom_range(0, 1) == 0) ? LoadOp : LoadbOp;
            rst = ($urandom_range(0, 63) == 0);
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), c);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
